// File: rtl/sbox_pipe.sv
// AES SubBytes / InvSubBytes unit: LANES independent bytes per beat through a
// STAGES-deep valid/ready pipeline with full backpressure and a per-beat mode tag.
`timescale 1ns/1ps
module sbox_pipe #(
   parameter int LANES  = 4,
   parameter int STAGES = 2,
   parameter bit INV_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_inv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic               out_inv,
   output logic               busy
);
   localparam int W = 8*LANES;

   if (LANES < 1 || LANES > 16) begin : g_bad_lanes
      $error("sbox_pipe: LANES must be in 1..16");
   end
   if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("sbox_pipe: STAGES must be in 1..3");
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // Front half shared by both directions: optional inverse affine, then field inverse.
   function automatic logic [W-1:0] sub_front(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++)
         r[8*k +: 8] = gf_inv(inv ? inv_affine(d[8*k +: 8]) : d[8*k +: 8]);
      return r;
   endfunction

   function automatic logic [W-1:0] sub_back(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++)
         r[8*k +: 8] = inv ? d[8*k +: 8] : fwd_affine(d[8*k +: 8]);
      return r;
   endfunction

   logic              mode_in;
   logic [W-1:0]      head;
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] m;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] nxt_v;
   logic [STAGES-1:0] nxt_m;
   logic [W-1:0]      d     [STAGES];
   logic [W-1:0]      nxt_d [STAGES];

   assign mode_in = INV_EN & in_inv;

   if (STAGES == 1) begin : g_head_full
      assign head = sub_back(sub_front(in_data, mode_in), mode_in);
   end else begin : g_head_split
      assign head = sub_front(in_data, mode_in);
   end

   // A stage may move when its successor is empty or itself moving, so bubbles collapse.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = out_ready;
      for (int i = STAGES-2; i >= 0; i--)
         adv[i] = !v[i+1] || adv[i+1];
   end

   // The back half of the substitution sits between stage 0 and stage 1 when there is one.
   always_comb begin
      nxt_v[0] = in_valid;
      nxt_m[0] = mode_in;
      nxt_d[0] = head;
      for (int i = 1; i < STAGES; i++) begin
         nxt_v[i] = v[i-1];
         nxt_m[i] = m[i-1];
         nxt_d[i] = (i == 1) ? sub_back(d[0], m[0]) : d[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v <= '0;
         m <= '0;
         for (int i = 0; i < STAGES; i++) d[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (!v[i] || adv[i]) begin
               v[i] <= nxt_v[i];
               m[i] <= nxt_m[i];
               d[i] <= nxt_d[i];
            end
         end
      end
   end

   assign in_ready  = !v[0] || adv[0];
   assign out_valid = v[STAGES-1];
   assign out_data  = d[STAGES-1];
   assign out_inv   = m[STAGES-1];
   assign busy      = |v;

endmodule

// File: tb/tb_sbox_pipe.sv
// Directed and scoreboard checks of sbox_pipe against the FIPS-197 S-box table,
// plus parameter-corner instances (1/1, 16/3, forward-only).
`timescale 1ns/1ps
module tb_sbox_pipe;
   localparam int LANES  = 4;
   localparam int STAGES = 2;

   typedef struct {
      logic [31:0] data;
      logic        inv;
      logic [31:0] exp_data;
      logic        exp_inv;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        inv;
      int          cyc;
   } sb_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
   logic [31:0] in_data, out_data;

   logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_inv, b_busy;
   logic [7:0]   b_in_data, b_out_data;
   logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_inv, c_busy;
   logic [127:0] c_in_data, c_out_data;
   logic         d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_inv, d_busy;
   logic [31:0]  d_in_data, d_out_data;

   sbox_pipe #(.LANES(4), .STAGES(2), .INV_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_inv(out_inv), .busy(busy));

   sbox_pipe #(.LANES(1), .STAGES(1), .INV_EN(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid), .out_ready(1'b1),
      .out_data(b_out_data), .out_inv(b_out_inv), .busy(b_busy));

   sbox_pipe #(.LANES(16), .STAGES(3), .INV_EN(1'b1)) dut_c (
      .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_inv(c_in_inv), .out_valid(c_out_valid), .out_ready(1'b1),
      .out_data(c_out_data), .out_inv(c_out_inv), .busy(c_busy));

   sbox_pipe #(.LANES(4), .STAGES(2), .INV_EN(1'b0)) dut_d (
      .clk(clk), .reset_n(reset_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_data(d_in_data), .in_inv(d_in_inv), .out_valid(d_out_valid), .out_ready(1'b1),
      .out_data(d_out_data), .out_inv(d_out_inv), .busy(d_busy));

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc          = 0;
   logic        mon_en       = 1'b0;
   logic        check_lat    = 1'b0;
   logic [7:0]  fwd_tab [256];
   logic [7:0]  inv_tab [256];
   sb_t         sb [$];
   vec_t        vecs [8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] din, input logic inv);
      logic [31:0] r;
      logic [7:0]  bt;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         bt = din[8*k +: 8];
         r[8*k +: 8] = inv ? inv_tab[bt] : fwd_tab[bt];
      end
      return r;
   endfunction

   // Presents one beat to the main instance and returns one edge after it is taken.
   task automatic applyStimulus(input logic [31:0] din, input logic inv);
      int   n;
      logic took;
      n = 0;
      took = 1'b0;
      in_valid = 1'b1;
      in_data  = din;
      in_inv   = inv;
      do begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 200);
      if (!took) checkOutput("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {127'd0, (sb.size() == 0 && !busy)}, 128'd1);
   endtask

   initial begin
      sb_t         e;
      logic        stall_prev;
      logic [31:0] held_d;
      logic        held_m;
      stall_prev = 1'b0;
      held_d = '0;
      held_m = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en || !reset_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev && out_valid) begin
               checkOutput("stall_hold_data", out_data, held_d);
               checkOutput("stall_hold_inv", out_inv, held_m);
            end
            if (out_valid && out_ready) begin
               checkOutput("sb_nonempty", {127'd0, sb.size() != 0}, 128'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  checkOutput("sb_data", out_data, e.data);
                  checkOutput("sb_inv", out_inv, e.inv);
                  if (check_lat) checkOutput("latency", cyc - e.cyc, STAGES);
               end
            end
            if (in_valid && in_ready) begin
               e.data = model(in_data, in_inv);
               e.inv  = in_inv;
               e.cyc  = cyc;
               sb.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_m = out_inv;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [0:15][127:0] rows;
      logic [7:0]  perm [256];
      logic [7:0]  tmp;
      logic [31:0] bp_beats [8];
      logic        took;
      int          n, c0, sent, guard;

      rows = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
              128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
              128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
              128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
              128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
              128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
              128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
              128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            fwd_tab[16*r + c] = rows[r][127-8*c -: 8];
      for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = i[7:0];

      vecs[0] = '{32'hFF530100, 1'b0, 32'h16ED7C63, 1'b0};
      vecs[1] = '{32'h16ED7C63, 1'b1, 32'hFF530100, 1'b1};
      vecs[2] = '{32'h00000000, 1'b0, 32'h63636363, 1'b0};
      vecs[3] = '{32'h10203040, 1'b0, 32'hCAB70409, 1'b0};
      vecs[4] = '{32'hCAB70409, 1'b1, 32'h10203040, 1'b1};
      vecs[5] = '{32'h0F0E0D0C, 1'b0, 32'h76ABD7FE, 1'b0};
      vecs[6] = '{32'h63636363, 1'b1, 32'h00000000, 1'b1};
      vecs[7] = '{32'hAA55F001, 1'b0, 32'hACFC8C7C, 1'b0};

      reset_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_inv = 1'b0;
      c_in_valid = 1'b0; c_in_data = '0; c_in_inv = 1'b0;
      d_in_valid = 1'b0; d_in_data = '0; d_in_inv = 1'b0;

      @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_inv", out_inv, 0);
      checkOutput("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", in_ready, 1);

      // Two beats in flight, then an asynchronous reset must wipe them at once.
      @(posedge clk); #1;
      applyStimulus(32'h04030201, 1'b0);
      applyStimulus(32'h08070605, 1'b1);
      @(negedge clk);
      checkOutput("pre_rst_out_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", out_valid, 0);
      checkOutput("mid_rst_out_data", out_data, 0);
      checkOutput("mid_rst_out_inv", out_inv, 0);
      checkOutput("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("rel_in_ready", in_ready, 1);
      repeat (3) begin
         @(negedge clk);
         checkOutput("no_stale_beat", out_valid, 0);
      end

      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_data = 8'h00; b_in_inv = 1'b0;
      @(negedge clk);
      checkOutput("b_in_ready", b_in_ready, 1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("b_out_valid", b_out_valid, 1);
      checkOutput("b_fwd_00", b_out_data, 8'h63);
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_data = 8'h63; b_in_inv = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("b_inv_63", b_out_data, 8'h00);
      checkOutput("b_out_inv", b_out_inv, 1);

      @(posedge clk); #1;
      c_in_valid = 1'b1; c_in_data = {16{8'h53}}; c_in_inv = 1'b0;
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("c_early_valid", c_out_valid, 0);
      end
      @(negedge clk);
      checkOutput("c_out_valid", c_out_valid, 1);
      checkOutput("c_fwd_53", c_out_data, {16{8'hED}});

      @(posedge clk); #1;
      d_in_valid = 1'b1; d_in_data = 32'h63636363; d_in_inv = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("d_out_valid", d_out_valid, 1);
      checkOutput("d_fwd_only", d_out_data, 32'hFBFBFBFB);
      checkOutput("d_out_inv", d_out_inv, 0);

      mon_en = 1'b1;
      check_lat = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         applyStimulus(vecs[i].data, vecs[i].inv);
         repeat (STAGES-1) @(posedge clk);
         @(negedge clk);
         checkOutput("vec_valid", out_valid, 1);
         checkOutput("vec_data", out_data, vecs[i].exp_data);
         checkOutput("vec_inv", out_inv, vecs[i].exp_inv);
      end

      // Every byte value once, arranged so the first beat is 00,01,53,FF.
      for (int i = 0; i < 256; i++) perm[i] = i[7:0];
      tmp = perm[2];   perm[2] = perm[8'h53];   perm[8'h53] = tmp;
      tmp = perm[3];   perm[3] = perm[8'hFF];   perm[8'hFF] = tmp;
      @(posedge clk); #1;
      c0 = cyc;
      for (int j = 0; j < 64; j++)
         applyStimulus({perm[4*j+3], perm[4*j+2], perm[4*j+1], perm[4*j]}, 1'b0);
      checkOutput("sweep_one_per_cycle", cyc - c0, 64);
      waitDrain("sweep_drain");

      @(posedge clk); #1;
      for (int j = 0; j < 8; j++) applyStimulus($urandom, j[0]);
      waitDrain("alt_drain");

      check_lat = 1'b0;
      for (int j = 0; j < 8; j++) bp_beats[j] = $urandom;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_data = bp_beats[n]; in_inv = n[0];
         @(negedge clk);
         checkOutput("bp_in_ready", in_ready, (n < STAGES));
         took = in_ready;
         @(posedge clk); #1;
         if (took) n++;
      end
      checkOutput("bp_buffered", n, STAGES);
      checkOutput("bp_busy", busy, 1);
      out_ready = 1'b1;
      for (int j = n; j < 8; j++) applyStimulus(bp_beats[j], j[0]);
      waitDrain("bp_drain");

      // Random valid/ready traffic; the input holds its beat until taken.
      sent = 0;
      took = 1'b0;
      in_valid = 1'b0;
      for (guard = 0; guard < 60000 && sent < 10000; guard++) begin
         @(posedge clk); #1;
         if (in_valid && took) begin
            sent++;
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_inv   = $urandom_range(0, 1) != 0;
         end
         @(negedge clk);
         took = in_ready;
      end
      checkOutput("random_sent", sent, 10000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      waitDrain("random_drain");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
